axis_param_fifo: RTL

AXIS_PARAM_FIFO -- requirements
Module: axis_param_fifo

---
 rtl/axis_param_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axis_param_fifo.sv
// First-word-fall-through AXI-Stream style FIFO with registered m_ready and EMPTY/PARTIAL/FULL tracking.
// Define AXIS_PKT_COUNT_EN to add the pkt_count output (stored entries whose last flag is set).
module axis_param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     m_data_in,
    input  logic                      m_valid,
    input  logic                      m_last,
    output logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     s_data_out,
    output logic                      s_valid,
    output logic                      s_last,
    input  logic                      s_ready,
`ifdef AXIS_PKT_COUNT_EN
    output logic [$clog2(DEPTH):0]    pkt_count,
`endif
    output logic [$clog2(DEPTH):0]    fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] C_ONE  = FW'(1);
    localparam logic [FW-1:0] C_LAST = FW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FW-1:0]         r_fill;
    logic [FW-1:0]         w_fill_nxt;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  r_m_ready;
    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_s_valid;
    logic                  w_push;
    logic                  w_pop;

    assign w_s_valid = (r_state != ST_EMPTY);
    assign w_push    = m_valid & r_m_ready;
    assign w_pop     = w_s_valid & s_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_PARTIAL;
                    w_fill_nxt  = C_ONE;
                end
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop) begin
                    w_fill_nxt = r_fill + C_ONE;
                    if (r_fill == C_LAST) begin
                        w_state_nxt = ST_FULL;
                    end
                end else if (w_pop && !w_push) begin
                    w_fill_nxt = r_fill - C_ONE;
                    if (r_fill == C_ONE) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            ST_FULL: begin
                // m_ready is low here, so a pop is the only possible event
                if (w_pop) begin
                    w_state_nxt = ST_PARTIAL;
                    w_fill_nxt  = r_fill - C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_fill_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_EMPTY;
            r_fill    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fill    <= w_fill_nxt;
            r_m_ready <= (w_state_nxt != ST_FULL);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {m_last, m_data_in};
        end
    end

    // Storage is never reset, so the head is masked while empty to keep outputs clean
    assign w_head     = r_mem[r_rd_ptr];
    assign s_data_out = w_s_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign s_last     = w_s_valid & w_head[DATA_WIDTH];
    assign s_valid    = w_s_valid;
    assign m_ready    = r_m_ready;
    assign fill_level = r_fill;

`ifdef AXIS_PKT_COUNT_EN
    logic [FW-1:0] r_pkt_count;
    logic          w_pkt_inc;
    logic          w_pkt_dec;

    assign w_pkt_inc = w_push & m_last;
    assign w_pkt_dec = w_pop & s_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_count <= '0;
        end else if (w_pkt_inc && !w_pkt_dec) begin
            r_pkt_count <= r_pkt_count + C_ONE;
        end else if (w_pkt_dec && !w_pkt_inc) begin
            r_pkt_count <= r_pkt_count - C_ONE;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule
